ras_ckpt_stack: RTL and testbench

RAS_CKPT_STACK -- requirements
Module: ras_ckpt_stack

---
 rtl/ras_ckpt_stack.sv | 104 ++++++++++
 tb/tb_ras_ckpt_stack.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ras_ckpt_stack.sv
// Return-address stack with checkpoint restore for speculative fetch.
// Circular storage: a full stack silently overwrites its oldest entry on push.
module ras_ckpt_stack #(
    parameter int RAS_ENTRIES = 16,
    parameter int PC_WIDTH = 38,
    localparam int LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES)
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       push_valid,
    input  logic [PC_WIDTH-1:0]        push_pc,
    input  logic                       pop_valid,
    input  logic                       restore_valid,
    input  logic [LOG_RAS_ENTRIES-1:0] restore_idx,
    input  logic [LOG_RAS_ENTRIES:0]   restore_count,
    input  logic                       restore_push_valid,
    input  logic [PC_WIDTH-1:0]        restore_push_pc,
    output logic [PC_WIDTH-1:0]        ret_pc,
    output logic [LOG_RAS_ENTRIES-1:0] top_idx,
    output logic [LOG_RAS_ENTRIES:0]   count,
    output logic                       empty,
    output logic                       full
);

    // Requests are single-cycle valid strobes with no ready: every request
    // present at a rising edge is accepted on that edge; restore outranks push/pop.

    localparam int CW = LOG_RAS_ENTRIES + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(RAS_ENTRIES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW:0] WIDE_FULL = (CW+1)'(RAS_ENTRIES);
    localparam logic [CW:0] WIDE_ONE = (CW+1)'(1);
    localparam logic [LOG_RAS_ENTRIES-1:0] IDX_ONE = LOG_RAS_ENTRIES'(1);

    logic [PC_WIDTH-1:0]        entries [RAS_ENTRIES];
    logic [LOG_RAS_ENTRIES-1:0] top_q;
    logic [CW-1:0]              count_q;

    logic [LOG_RAS_ENTRIES-1:0] next_top;
    logic [CW-1:0]              next_count;
    logic                       wr_en;
    logic [LOG_RAS_ENTRIES-1:0] wr_idx;
    logic [PC_WIDTH-1:0]        wr_data;
    logic [CW:0]                restore_inc;

    // One extra bit so a checkpointed count near 2*RAS_ENTRIES cannot wrap before clamping.
    assign restore_inc = {1'b0, restore_count} + WIDE_ONE;

    always_comb begin
        next_top   = top_q;
        next_count = count_q;
        wr_en      = 1'b0;
        wr_idx     = top_q;
        wr_data    = push_pc;
        if (restore_valid) begin
            if (restore_push_valid) begin
                next_top   = restore_idx + IDX_ONE;
                wr_en      = 1'b1;
                wr_idx     = restore_idx + IDX_ONE;
                wr_data    = restore_push_pc;
                next_count = (restore_inc > WIDE_FULL) ? FULL_COUNT : restore_inc[CW-1:0];
            end else begin
                next_top   = restore_idx;
                next_count = (restore_count > FULL_COUNT) ? FULL_COUNT : restore_count;
            end
        end else if (push_valid && pop_valid) begin
            // Call and return together replace the top in place.
            wr_en      = 1'b1;
            wr_idx     = top_q;
            next_count = (count_q == '0) ? CNT_ONE : count_q;
        end else if (push_valid) begin
            next_top   = top_q + IDX_ONE;
            wr_en      = 1'b1;
            wr_idx     = top_q + IDX_ONE;
            next_count = (count_q == FULL_COUNT) ? FULL_COUNT : count_q + CNT_ONE;
        end else if (pop_valid && count_q != '0) begin
            next_top   = top_q - IDX_ONE;
            next_count = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            top_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                entries[i] <= '0;
            end
        end else begin
            top_q   <= next_top;
            count_q <= next_count;
            if (wr_en) begin
                entries[wr_idx] <= wr_data;
            end
        end
    end

    assign ret_pc  = entries[top_q];
    assign top_idx = top_q;
    assign count   = count_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_COUNT);

endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Directed and random stimulus for ras_ckpt_stack, checked against a
// behavioural stack model through an expected-value queue.
module tb_ras_ckpt_stack;

    localparam int N   = 16;
    localparam int PCW = 38;
    localparam int L   = 4;
    localparam int CW  = L + 1;
    localparam int W   = PCW + L + CW + 2;

    logic           CLK = 1'b0;
    logic           nRST = 1'b0;
    logic           push_valid = 1'b0;
    logic [PCW-1:0] push_pc = '0;
    logic           pop_valid = 1'b0;
    logic           restore_valid = 1'b0;
    logic [L-1:0]   restore_idx = '0;
    logic [CW-1:0]  restore_count = '0;
    logic           restore_push_valid = 1'b0;
    logic [PCW-1:0] restore_push_pc = '0;
    logic [PCW-1:0] ret_pc;
    logic [L-1:0]   top_idx;
    logic [CW-1:0]  count;
    logic           empty;
    logic           full;

    ras_ckpt_stack #(.RAS_ENTRIES(N), .PC_WIDTH(PCW)) dut (
        .CLK(CLK),
        .nRST(nRST),
        .push_valid(push_valid),
        .push_pc(push_pc),
        .pop_valid(pop_valid),
        .restore_valid(restore_valid),
        .restore_idx(restore_idx),
        .restore_count(restore_count),
        .restore_push_valid(restore_push_valid),
        .restore_push_pc(restore_push_pc),
        .ret_pc(ret_pc),
        .top_idx(top_idx),
        .count(count),
        .empty(empty),
        .full(full)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    logic [PCW-1:0] m_mem [N];
    int m_top;
    int m_cnt;

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference stack: plain integer arithmetic with explicit modulo wrap.
    task automatic model(input bit rst, input bit push, input bit pop, input bit rest,
                         input bit rpush, input int ridx, input int rcnt,
                         input logic [PCW-1:0] pc, input logic [PCW-1:0] rpc);
        if (rst) begin
            m_top = 0;
            m_cnt = 0;
            for (int i = 0; i < N; i++) m_mem[i] = '0;
        end else if (rest) begin
            if (rpush) begin
                m_top = (ridx + 1) % N;
                m_mem[m_top] = rpc;
                m_cnt = (rcnt + 1 > N) ? N : rcnt + 1;
            end else begin
                m_top = ridx;
                m_cnt = (rcnt > N) ? N : rcnt;
            end
        end else if (push && pop) begin
            m_mem[m_top] = pc;
            if (m_cnt == 0) m_cnt = 1;
        end else if (push) begin
            m_top = (m_top + 1) % N;
            m_mem[m_top] = pc;
            if (m_cnt < N) m_cnt = m_cnt + 1;
        end else if (pop && m_cnt > 0) begin
            m_top = (m_top + N - 1) % N;
            m_cnt = m_cnt - 1;
        end
        exp_q.push_back({m_mem[m_top], m_top[L-1:0], m_cnt[CW-1:0],
                         (m_cnt == 0), (m_cnt == N)});
    endtask

    task automatic check_out(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
            return;
        end
        e = exp_q.pop_front();
        cmp({tag, "_ret_pc"}, 64'(ret_pc), 64'(e[W-1 -: PCW]));
        cmp({tag, "_top_idx"}, 64'(top_idx), 64'(e[W-PCW-1 -: L]));
        cmp({tag, "_count"}, 64'(count), 64'(e[CW+1:2]));
        cmp({tag, "_empty"}, 64'(empty), 64'(e[1]));
        cmp({tag, "_full"}, 64'(full), 64'(e[0]));
    endtask

    task automatic step(input string tag, input bit rst, input bit push, input bit pop,
                        input bit rest, input bit rpush, input int ridx, input int rcnt,
                        input logic [PCW-1:0] pc, input logic [PCW-1:0] rpc);
        nRST = ~rst;
        push_valid = push;
        pop_valid = pop;
        push_pc = pc;
        restore_valid = rest;
        restore_push_valid = rpush;
        restore_idx = ridx[L-1:0];
        restore_count = rcnt[CW-1:0];
        restore_push_pc = rpc;
        model(rst, push, pop, rest, rpush, ridx, rcnt, pc, rpc);
        @(posedge CLK);
        #1;
        check_out(tag);
    endtask

    task automatic do_reset(input bit with_push);
        step("reset", 1'b1, with_push, 1'b0, 1'b0, 1'b0, 0, 0, 38'h3ff, '0);
    endtask

    task automatic do_push(input logic [PCW-1:0] pc);
        step("push", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, pc, '0);
    endtask

    task automatic do_pop();
        step("pop", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, '0, '0);
    endtask

    initial begin
        logic [PCW-1:0] rpc;
        logic [PCW-1:0] ppc;
        int r;

        // Reset overrides a concurrent push.
        do_reset(1'b1);
        do_reset(1'b1);
        cmp("rst_count", 64'(count), 64'd0);
        cmp("rst_top", 64'(top_idx), 64'd0);
        cmp("rst_ret", 64'(ret_pc), 64'd0);
        cmp("rst_empty", 64'(empty), 64'd1);

        do_push(38'h100);
        do_push(38'h200);
        do_push(38'h300);
        cmp("s1_top", 64'(top_idx), 64'd3);
        cmp("s1_count", 64'(count), 64'd3);
        cmp("s1_ret", 64'(ret_pc), 64'h300);
        do_pop();
        cmp("s1_pop_ret", 64'(ret_pc), 64'h200);
        cmp("s1_pop_count", 64'(count), 64'd2);

        // Overflow wraps onto the oldest entry.
        do_reset(1'b0);
        for (int i = 1; i <= 17; i++) do_push(PCW'(i));
        cmp("s2_full", 64'(full), 64'd1);
        cmp("s2_count", 64'(count), 64'd16);
        cmp("s2_top", 64'(top_idx), 64'd1);
        cmp("s2_ret", 64'(ret_pc), 64'h11);
        for (int i = 0; i < 16; i++) do_pop();
        cmp("s2_empty", 64'(empty), 64'd1);
        do_pop();
        cmp("s2_underflow_top", 64'(top_idx), 64'd1);
        cmp("s2_underflow_count", 64'(count), 64'd0);

        // Simultaneous push and pop replaces the top.
        do_reset(1'b0);
        do_push(38'hA);
        do_push(38'hB);
        step("pushpop", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 38'hC, '0);
        cmp("s3_top", 64'(top_idx), 64'd2);
        cmp("s3_count", 64'(count), 64'd2);
        cmp("s3_ret", 64'(ret_pc), 64'hC);

        // Restore to checkpoint (2,2); concurrent push must be ignored.
        do_push(38'hD);
        do_push(38'hE);
        do_pop();
        step("restore", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2, 2, 38'h77, '0);
        cmp("s4_top", 64'(top_idx), 64'd2);
        cmp("s4_count", 64'(count), 64'd2);
        cmp("s4_ret", 64'(ret_pc), 64'hC);

        // Restore with push wraps the index and clamps the count.
        step("restore_push", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 15, 16, '0, 38'h3F);
        cmp("s5_top", 64'(top_idx), 64'd0);
        cmp("s5_count", 64'(count), 64'd16);
        cmp("s5_ret", 64'(ret_pc), 64'h3F);

        step("restore_clamp", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5, 31, '0, '0);
        cmp("s6_count", 64'(count), 64'd16);
        step("restore_push_clamp", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9, 31, '0, 38'h2A);
        step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 38'h55, '0);

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 39));
            ppc = {6'($urandom), 32'($urandom)};
            rpc = {6'($urandom), 32'($urandom)};
            if (r == 0) begin
                step("rand_reset", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3, 3, ppc, rpc);
            end else if (r < 4) begin
                step("rand_restore", 1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'($urandom),
                     int'($urandom_range(0, N - 1)), int'($urandom_range(0, 2 * N - 1)), ppc, rpc);
            end else begin
                step("rand_op", 1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'($urandom),
                     0, 0, ppc, rpc);
            end
        end

        cmp("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
